seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Multiplexed seven-segment display driver: the display-side consumer of the ALU's 4-bit results. It accepts a packed hex word on a load strobe and decodes one nibble per digit. It time-multiplexes the digits onto a shared active-low segment bus with active-low digit enables. New values are double-buffered and committed only at frame boundaries, so a digit never shows a mix of old and new data.

## Interface
- DIGITS, 4: number of digits/nibbles (2..8)
- DIV, 50000: clk cycles per digit slot (≥2)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- load  in  1  single-cycle strobe; captures `value` into the shadow register
- value  in  4*DIGITS  hex nibbles; nibble i = value[4i+3:4i], digit 0 = least significant
- blank_lz  in  1  1 = blank leading-zero digits (digit 0 never blanked)
- pending  out  1  shadow holds data not yet committed to display
- anode_n  out  DIGITS  one-hot-low digit enable, registered
- seg_n  out  7  {g,f,e,d,c,b,a}, active-low, registered

## Operation
- Divider `div` counts 0..DIV-1 and wraps. `tick` = (div == DIV-1).
- Digit index `idx` advances on tick, wraps DIGITS-1 -> 0. A frame starts on the tick where idx wraps.
- Load handling: on load, shadow <= value and pending <= 1.
- Commit: on a frame-start tick with pending == 1, disp <= shadow (pre-edge contents) and pending <= 0.
- Load and commit on the same cycle: disp takes the old shadow, shadow takes the new value, and pending stays 1.
- Back-to-back loads before a commit: the last one wins. No loss indication.
- Output register:
  - anode_n <= ~(1 << idx).
  - seg_n <= decode(disp nibble idx), or 7'h7F when the digit is blanked.
- Blanking, when blank_lz == 1: digit i>0 is blank if nibbles i..DIGITS-1 of disp are all zero. Example: disp 16'h00A0 shows " A0".
- Decode table (seg_n hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Reset, synchronous, wins over load:
  - div=0, idx=0, shadow=0, disp=0, pending=0.
  - anode_n = all ones, seg_n = 7'h7F.
  - Reset asserted mid-frame aborts the frame. Uncommitted shadow data is lost.

## Timing
- Cycle 0 = first edge with rst low.
- After cycle 0's edge, anode_n = ~1 and seg_n = 7'h40 (digit 0, value 0). blank_lz does not affect digit 0.
- idx changes on the edge where tick is high. anode_n/seg_n follow one cycle later (1-cycle output latency).
- Each digit is driven for exactly DIV cycles. Frame = DIGITS*DIV cycles.
- pending rises on the edge after load and falls on the commit edge.
- Load-to-visible latency: commit-edge wait of 1..DIGITS*DIV cycles, plus 1 output cycle.
- A change in blank_lz is reflected at the next output-register update, with no frame alignment.

## Structure
- Package `seg7_pkg`:
  - `seg_t` (logic [6:0])
  - `SEG_BLANK` = 7'h7F
  - 16-entry constant array `SEG_HEX` of the decode table above
- Sub-module `hex_to_seg7`: combinational nibble -> seg_t using `SEG_HEX`. It is reused by other display paths.
- Top module holds the divider, index counter, shadow/disp registers, blanking logic and output registers.

## Test plan
Benches use DIGITS=4, DIV=4 unless noted.
- Reset/scan: release rst, no load. Anode_n cycles E,D,B,7, 4 cycles each, repeating every 16 cycles. seg_n = 40 on digit 0 and on every digit when blank_lz=0; 7F on digits 1-3 when blank_lz=1.
- Load/commit: load 16'h5B9C mid-frame. pending=1 until the next wrap tick, then digits show C,9,b,5 (seg_n 46,10,03,12) and pending=0.
- Simultaneous load at commit: load 16'h1234, then load 16'hABCD exactly on the wrap tick. That frame shows 1234, pending stays 1, and the following frame shows ABCD.
- Leading-zero blanking: load 16'h0070 with blank_lz=1. Digits 3,2 show 7F, digit 1 shows 78, digit 0 shows 40. Toggle blank_lz=0: digits 3,2 show 40.
- Reset mid-operation: rst for 1 cycle mid-frame with pending=1. Next cycle anode_n=F, seg_n=7F, pending=0. Scan then restarts at digit 0 showing 0000.
- Exhaustive decode: load each of the values 0..F into nibble 0 and check seg_n against the table. Bench with DIGITS=8 checks the 128-cycle frame length.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seven-segment types and decode table
//   seg_t     : segment vector {g,f,e,d,c,b,a}, active-low
//   SEG_BLANK : all segments off
//   SEG_HEX   : active-low patterns for hex digits 0..F
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam seg_t SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational hex nibble to active-low segment decoder
//   nibble : 4-bit hex value
//   seg    : {g,f,e,d,c,b,a}, active-low
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed seven-segment scan driver with frame-aligned commit
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   load     : one-cycle strobe capturing value into the shadow register
//   value    : packed hex nibbles, nibble 0 = least significant digit
//   blank_lz : blank leading-zero digits (digit 0 always shown)
//   pending  : shadow holds data not yet committed to the display
//   anode_n  : one-hot-low digit enable, registered
//   seg_n    : {g,f,e,d,c,b,a}, active-low, registered
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  blank_lz,
  output logic                  pending,
  output logic [DIGITS-1:0]     anode_n,
  output seg_t                  seg_n
);

  localparam int DW = $clog2(DIV);
  localparam int IW = $clog2(DIGITS);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [DW-1:0]       div;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] shadow;
  logic [4*DIGITS-1:0] disp;

  logic                tick;
  logic                frame_start;
  logic                commit;

  logic [3:0]          cur_nib;
  seg_t                dec_seg;
  logic [DIGITS-1:0]   lz_vec;
  logic                upper_zero;
  logic [DIGITS-1:0]   digit_onehot;
  logic [DIGITS-1:0]   anode_next;
  seg_t                seg_next;

  assign tick        = (div == DIV_LAST);
  assign frame_start = tick && (idx == IDX_LAST);
  assign commit      = frame_start && pending;

  // Slot timing: each digit owns the bus for exactly DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
      idx <= '0;
    end else begin
      if (tick) begin
        div <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

  // Double buffer. The commit reads the pre-edge shadow, so a load landing on
  // the commit edge is kept for the following frame and pending stays set.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow  <= '0;
      disp    <= '0;
      pending <= 1'b0;
    end else begin
      if (load) begin
        shadow <= value;
      end
      if (commit) begin
        disp <= shadow;
      end
      if (load) begin
        pending <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
    end
  end

  // Digit i (i > 0) is a leading zero when it and every digit above it are 0.
  always_comb begin
    upper_zero = 1'b1;
    lz_vec     = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero & (disp[4*i +: 4] == 4'h0);
      lz_vec[i]  = upper_zero;
    end
  end

  assign cur_nib = disp[{idx, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  always_comb begin
    digit_onehot      = '0;
    digit_onehot[idx] = 1'b1;
    anode_next        = ~digit_onehot;
    seg_next          = (blank_lz && lz_vec[idx]) ? SEG_BLANK : dec_seg;
  end

  // Output register: the bus shows the digit selected during the previous cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      anode_n <= '1;
      seg_n   <= SEG_BLANK;
    end else begin
      anode_n <= anode_next;
      seg_n   <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic        blank_lz;
  logic        pending;
  logic [3:0]  anode_n;
  logic [6:0]  seg_n;

  logic        rst8;
  logic        load8;
  logic [31:0] value8;
  logic        blank_lz8;
  logic        pending8;
  logic [7:0]  anode_n8;
  logic [6:0]  seg_n8;

  int checks = 0;
  int errors = 0;
  int next_k = 0;

  logic [6:0] dec_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  seg7_scan_driver #(.DIGITS(4), .DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .value    (value),
    .blank_lz (blank_lz),
    .pending  (pending),
    .anode_n  (anode_n),
    .seg_n    (seg_n)
  );

  seg7_scan_driver #(.DIGITS(8), .DIV(16)) dut8 (
    .clk      (clk),
    .rst      (rst8),
    .load     (load8),
    .value    (value8),
    .blank_lz (blank_lz8),
    .pending  (pending8),
    .anode_n  (anode_n8),
    .seg_n    (seg_n8)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    next_k++;
  endtask

  task automatic step_to(input int k);
    while (next_k < k) step();
  endtask

  // Steps one 16-cycle frame of the 4-digit DUT; segs holds digit d at [7*d +: 7].
  task automatic frame_check(input string tag, input logic [27:0] segs);
    int d;
    logic [3:0] want_an;
    for (int i = 0; i < 16; i++) begin
      step();
      d = i / 4;
      want_an = ~(4'b0001 << d);
      chk({tag, "_anode"}, {28'h0, anode_n}, {28'h0, want_an});
      chk({tag, "_seg"}, {25'h0, seg_n}, {25'h0, segs[7*d +: 7]});
    end
  endtask

  initial begin
    int d8;
    logic [7:0] want8;

    rst = 1'b1; load = 1'b0; value = '0; blank_lz = 1'b0;
    rst8 = 1'b1; load8 = 1'b0; value8 = '0; blank_lz8 = 1'b0;
    step(); step(); step();
    chk("reset_anode", {28'h0, anode_n}, 32'hF);
    chk("reset_seg", {25'h0, seg_n}, 32'h7F);
    chk("reset_pending", {31'h0, pending}, 32'h0);

    // Scan after reset, no load
    rst = 1'b0;
    next_k = 0;
    frame_check("scan0", {7'h40, 7'h40, 7'h40, 7'h40});
    frame_check("scan1", {7'h40, 7'h40, 7'h40, 7'h40});
    blank_lz = 1'b1;
    frame_check("scan_blank", {7'h7F, 7'h7F, 7'h7F, 7'h40});

    // Mid-frame load, commit at next wrap
    step_to(51);
    load = 1'b1; value = 16'h5B9C;
    step();
    load = 1'b0;
    chk("load_pending_rise", {31'h0, pending}, 32'h1);
    step_to(63);
    chk("load_pending_hold", {31'h0, pending}, 32'h1);
    step();
    chk("commit_pending_fall", {31'h0, pending}, 32'h0);
    frame_check("show_5b9c", {7'h12, 7'h03, 7'h10, 7'h46});

    // Load on the commit edge itself
    step_to(85);
    load = 1'b1; value = 16'h1234;
    step();
    load = 1'b0;
    step_to(95);
    load = 1'b1; value = 16'hABCD;
    step();
    load = 1'b0;
    chk("simul_pending", {31'h0, pending}, 32'h1);
    frame_check("show_1234", {7'h79, 7'h24, 7'h30, 7'h19});
    chk("simul_pending_fall", {31'h0, pending}, 32'h0);
    frame_check("show_abcd", {7'h08, 7'h03, 7'h46, 7'h21});

    // Leading-zero blanking
    step_to(130);
    load = 1'b1; value = 16'h0070;
    step();
    load = 1'b0;
    step_to(144);
    frame_check("lz_on", {7'h7F, 7'h7F, 7'h78, 7'h40});
    blank_lz = 1'b0;
    frame_check("lz_off", {7'h40, 7'h40, 7'h78, 7'h40});

    // Reset mid-frame with pending data
    step_to(180);
    load = 1'b1; value = 16'h1111;
    step();
    load = 1'b0;
    step_to(186);
    chk("rst_mid_pending_pre", {31'h0, pending}, 32'h1);
    rst = 1'b1;
    step();
    chk("rst_mid_anode", {28'h0, anode_n}, 32'hF);
    chk("rst_mid_seg", {25'h0, seg_n}, 32'h7F);
    chk("rst_mid_pending", {31'h0, pending}, 32'h0);
    rst = 1'b0;
    next_k = 0;
    frame_check("post_rst0", {7'h40, 7'h40, 7'h40, 7'h40});
    frame_check("post_rst1", {7'h40, 7'h40, 7'h40, 7'h40});
    chk("post_rst_pending", {31'h0, pending}, 32'h0);

    // Every decode value on digit 0, with blanking on
    blank_lz = 1'b1;
    for (int v = 0; v < 16; v++) begin
      load = 1'b1; value = {12'h000, 4'(v)};
      step();
      load = 1'b0;
      while (next_k % 16 != 0) step();
      step();
      chk($sformatf("decode_%0h", v), {25'h0, seg_n}, {25'h0, dec_tab[v]});
      chk($sformatf("decode_anode_%0h", v), {28'h0, anode_n}, 32'hE);
    end

    // 8-digit instance: 128-cycle frame
    rst8 = 1'b1;
    step();
    chk("d8_reset_anode", {24'h0, anode_n8}, 32'hFF);
    chk("d8_reset_seg", {25'h0, seg_n8}, 32'h7F);
    rst8 = 1'b0;
    for (int e = 0; e <= 128; e++) begin
      step();
      d8 = (e / 16) % 8;
      want8 = ~(8'b0000_0001 << d8);
      chk($sformatf("d8_anode_e%0d", e), {24'h0, anode_n8}, {24'h0, want8});
      chk($sformatf("d8_seg_e%0d", e), {25'h0, seg_n8}, 32'h40);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
